// File: rtl/seq_multiplier_n_if.sv
// -----------------------------------------------------------------------------
// seq_multiplier_n_if
//
// Purpose : bundles the control, operand and result signals of the sequential
//           shift-add multiplier so the lab top level, the multiplier and the
//           display drivers share one connection object.
//
// Parameters
//   WIDTH        operand width in bits (4..32)
//
// Signals
//   ClearA_LoadB  master->slave  clear A/X and load B from S (IDLE only)
//   Run           master->slave  level; one multiplication per assertion
//   S             master->slave  multiplicand and load value for B
//   Unsigned      master->slave  only with SEQ_MULT_UNSIGNED_EN: unsigned mode
//   Aval          slave->master  upper product half (register A)
//   Bval          slave->master  lower product half (register B)
//   X             slave->master  sign-extension bit of A
//   Busy          slave->master  high while computing
//   Done          slave->master  high while holding a finished product
//
// Optional feature macro: SEQ_MULT_UNSIGNED_EN adds the Unsigned signal.
// -----------------------------------------------------------------------------
interface seq_multiplier_n_if #(
    parameter int WIDTH = 8
);
    logic             ClearA_LoadB;
    logic             Run;
    logic [WIDTH-1:0] S;
`ifdef SEQ_MULT_UNSIGNED_EN
    logic             Unsigned;
`endif
    logic [WIDTH-1:0] Aval;
    logic [WIDTH-1:0] Bval;
    logic             X;
    logic             Busy;
    logic             Done;

`ifdef SEQ_MULT_UNSIGNED_EN
    modport master (
        output ClearA_LoadB,
        output Run,
        output S,
        output Unsigned,
        input  Aval,
        input  Bval,
        input  X,
        input  Busy,
        input  Done
    );

    modport slave (
        input  ClearA_LoadB,
        input  Run,
        input  S,
        input  Unsigned,
        output Aval,
        output Bval,
        output X,
        output Busy,
        output Done
    );
`else
    modport master (
        output ClearA_LoadB,
        output Run,
        output S,
        input  Aval,
        input  Bval,
        input  X,
        input  Busy,
        input  Done
    );

    modport slave (
        input  ClearA_LoadB,
        input  Run,
        input  S,
        output Aval,
        output Bval,
        output X,
        output Busy,
        output Done
    );
`endif

endinterface : seq_multiplier_n_if

// File: rtl/seq_multiplier_n.sv
// -----------------------------------------------------------------------------
// seq_multiplier_n
//
// Purpose : WIDTH-generic sequential signed shift-add multiplier. B is loaded
//           into the low product register; each Run assertion multiplies S by
//           the current B over WIDTH compute cycles, leaving the 2*WIDTH-bit
//           product in A:B (X holds the sign extension of A). The result stays
//           in place, so the next Run multiplies S by the previous low half.
//
// Parameters
//   WIDTH         operand width in bits, legal range 4..32
//
// Ports
//   Clk           in   system clock, rising edge
//   Reset         in   asynchronous active-high reset
//   bus           slave modport of seq_multiplier_n_if:
//                   ClearA_LoadB, Run, S (and Unsigned) in;
//                   Aval, Bval, X, Busy, Done out (all registered)
//
// Optional feature macro: SEQ_MULT_UNSIGNED_EN
//   When defined, bus.Unsigned is sampled on the IDLE->COMPUTE transition and
//   selects zero-extended operands with an add (not subtract) on the final
//   step; X is cleared on HOLD entry. Undefined: signed-only operation.
// -----------------------------------------------------------------------------
module seq_multiplier_n #(
    parameter int WIDTH = 8
) (
    input  logic                 Clk,
    input  logic                 Reset,
    seq_multiplier_n_if.slave    bus
);

    // Counter only needs to reach WIDTH-1.
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COMPUTE = 2'b01,
        ST_HOLD    = 2'b10
    } state_t;

    // -------------------------------------------------------------------------
    // One shift-add iteration: produces the WIDTH+1 bit partial sum that is
    // then shifted right together with B. In signed mode the last multiplier
    // bit carries negative weight, hence the subtraction on the final step.
    // -------------------------------------------------------------------------
    function automatic logic [WIDTH:0] step_sum(
        input logic [WIDTH-1:0] a,
        input logic             x,
        input logic [WIDTH-1:0] s,
        input logic             b0,
        input logic             last,
        input logic             uns
    );
        logic [WIDTH:0] a_ext;
        logic [WIDTH:0] s_ext;
        logic [WIDTH:0] res;
        if (uns) begin
            a_ext = {1'b0, a};
            s_ext = {1'b0, s};
        end else begin
            a_ext = {a[WIDTH-1], a};
            s_ext = {s[WIDTH-1], s};
        end
        if (!b0) begin
            // Nothing to add: pass the (sign-)extended accumulator through.
            // In unsigned mode the previous carry already sits in A's MSB.
            if (uns) begin
                res = {1'b0, a};
            end else begin
                res = {x, a};
            end
        end else if (last && !uns) begin
            res = a_ext - s_ext;
        end else begin
            res = a_ext + s_ext;
        end
        return res;
    endfunction

    state_t            state_r;
    state_t            state_nx;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  a_nx;
    logic [WIDTH-1:0]  b_r;
    logic [WIDTH-1:0]  b_nx;
    logic              x_r;
    logic              x_nx;
    logic [CW-1:0]     count_r;
    logic [CW-1:0]     count_nx;
    logic              busy_r;
    logic              busy_nx;
    logic              done_r;
    logic              done_nx;
    logic              uns_s;
    logic              last_s;
    logic [WIDTH:0]    sum_s;

`ifdef SEQ_MULT_UNSIGNED_EN
    logic              uns_r;
    logic              uns_nx;

    assign uns_s = uns_r;
`else
    assign uns_s = 1'b0;
`endif

    assign last_s = (count_r == LAST_CNT);

    // Partial sum for the current compute iteration.
    always_comb begin
        sum_s = step_sum(a_r, x_r, bus.S, b_r[0], last_s, uns_s);
    end

    // Next-state and next-register decode for the control FSM and datapath.
    always_comb begin
        state_nx = state_r;
        a_nx     = a_r;
        b_nx     = b_r;
        x_nx     = x_r;
        count_nx = count_r;
`ifdef SEQ_MULT_UNSIGNED_EN
        uns_nx   = uns_r;
`endif
        case (state_r)
            ST_IDLE: begin
                // Loading B wins over Run; a held Run is taken on a later edge.
                if (bus.ClearA_LoadB) begin
                    a_nx = '0;
                    x_nx = 1'b0;
                    b_nx = bus.S;
                end else if (bus.Run) begin
                    a_nx     = '0;
                    x_nx     = 1'b0;
                    count_nx = '0;
                    state_nx = ST_COMPUTE;
`ifdef SEQ_MULT_UNSIGNED_EN
                    uns_nx   = bus.Unsigned;
`endif
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_COMPUTE: begin
                // Arithmetic right shift of sum:B.
                x_nx = sum_s[WIDTH];
                a_nx = sum_s[WIDTH:1];
                b_nx = {sum_s[0], b_r[WIDTH-1:1]};
                if (last_s) begin
                    state_nx = ST_HOLD;
                    // The unsigned carry lives in A's MSB now; X is not a sign.
                    if (uns_s) begin
                        x_nx = 1'b0;
                    end else begin
                        x_nx = sum_s[WIDTH];
                    end
                end else begin
                    count_nx = count_r + CW'(1);
                end
            end
            ST_HOLD: begin
                // Only a released Run re-arms; a held Run never restarts.
                if (!bus.Run) begin
                    state_nx = ST_IDLE;
                end else begin
                    state_nx = ST_HOLD;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Status flags registered from the next state so they never glitch.
    always_comb begin
        busy_nx = (state_nx == ST_COMPUTE);
        done_nx = (state_nx == ST_HOLD);
    end

    // FSM state register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Datapath and status registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            a_r     <= '0;
            b_r     <= '0;
            x_r     <= 1'b0;
            count_r <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            a_r     <= a_nx;
            b_r     <= b_nx;
            x_r     <= x_nx;
            count_r <= count_nx;
            busy_r  <= busy_nx;
            done_r  <= done_nx;
        end
    end

`ifdef SEQ_MULT_UNSIGNED_EN
    // Operation mode captured at start and held through the multiplication.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            uns_r <= 1'b0;
        end else begin
            uns_r <= uns_nx;
        end
    end
`endif

    assign bus.Aval = a_r;
    assign bus.Bval = b_r;
    assign bus.X    = x_r;
    assign bus.Busy = busy_r;
    assign bus.Done = done_r;

endmodule : seq_multiplier_n

// File: tb/tb_seq_multiplier_n.sv
// -----------------------------------------------------------------------------
// tb_seq_multiplier_n
//
// Directed bench for seq_multiplier_n: a WIDTH=8 instance carries most of the
// vectors, a WIDTH=16 instance covers the most-negative squared case. Expected
// products are hand-computed two's-complement values.
// -----------------------------------------------------------------------------
module tb_seq_multiplier_n;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    seq_multiplier_n_if #(.WIDTH(8))  bus8  ();
    seq_multiplier_n_if #(.WIDTH(16)) bus16 ();

    seq_multiplier_n #(.WIDTH(8)) u_dut8 (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus8)
    );

    seq_multiplier_n #(.WIDTH(16)) u_dut16 (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load8(input logic [7:0] v);
        bus8.S            = v;
        bus8.ClearA_LoadB = 1'b1;
        tick();
        bus8.ClearA_LoadB = 1'b0;
    endtask

    // Run with exact latency: Busy right after the Run edge, Done after 8 more.
    task automatic run8(input string tag, input logic [7:0] s);
        bus8.S   = s;
        bus8.Run = 1'b1;
        tick();
        chk({tag, "_busy"}, {31'd0, bus8.Busy}, 32'd1);
        repeat (7) tick();
        chk({tag, "_done_early"}, {31'd0, bus8.Done}, 32'd0);
        tick();
        chk({tag, "_done"}, {31'd0, bus8.Done}, 32'd1);
    endtask

    task automatic prod8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic x);
        chk({tag, "_A"}, {24'd0, bus8.Aval}, {24'd0, a});
        chk({tag, "_B"}, {24'd0, bus8.Bval}, {24'd0, b});
        chk({tag, "_X"}, {31'd0, bus8.X},    {31'd0, x});
    endtask

    task automatic release8(input string tag);
        bus8.Run = 1'b0;
        tick();
        chk({tag, "_rel_done"}, {31'd0, bus8.Done}, 32'd0);
        chk({tag, "_rel_busy"}, {31'd0, bus8.Busy}, 32'd0);
    endtask

    initial begin
        rst                = 1'b1;
        bus8.ClearA_LoadB  = 1'b0;
        bus8.Run           = 1'b0;
        bus8.S             = 8'h00;
        bus16.ClearA_LoadB = 1'b0;
        bus16.Run          = 1'b0;
        bus16.S            = 16'h0000;
`ifdef SEQ_MULT_UNSIGNED_EN
        bus8.Unsigned      = 1'b0;
        bus16.Unsigned     = 1'b0;
`endif
        #12;
        prod8("reset", 8'h00, 8'h00, 1'b0);
        chk("reset_busy", {31'd0, bus8.Busy}, 32'd0);
        chk("reset_done", {31'd0, bus8.Done}, 32'd0);
        rst = 1'b0;
        tick();

        // 1 * 8, then Done must persist while Run stays high.
        load8(8'h01);
        chk("load_B", {24'd0, bus8.Bval}, 32'h01);
        run8("p1x8", 8'h08);
        prod8("p1x8", 8'h00, 8'h08, 1'b0);
        repeat (3) tick();
        chk("hold_done", {31'd0, bus8.Done}, 32'd1);
        prod8("hold", 8'h00, 8'h08, 1'b0);
        release8("p1x8");

        // 1 * -1 = -1, then chained -2 * -1 = 2.
        load8(8'h01);
        run8("p1xm1", 8'hFF);
        prod8("p1xm1", 8'hFF, 8'hFF, 1'b1);
        release8("p1xm1");
        run8("chain", 8'hFE);
        prod8("chain", 8'h00, 8'h02, 1'b0);
        release8("chain");

        // Boundaries: zero operands, most-negative squared, max * min.
        load8(8'h5A);
        run8("s0", 8'h00);
        prod8("s0", 8'h00, 8'h00, 1'b0);
        release8("s0");
        run8("b0", 8'h7F);
        prod8("b0", 8'h00, 8'h00, 1'b0);
        release8("b0");
        load8(8'h80);
        run8("mneg", 8'h80);
        prod8("mneg", 8'h40, 8'h00, 1'b0);
        release8("mneg");
        load8(8'h80);
        run8("maxmin", 8'h7F);
        prod8("maxmin", 8'hC0, 8'h80, 1'b1);
        release8("maxmin");

        // ClearA_LoadB pulsed mid-compute is ignored: 0x55 * 3 = 0xFF.
        load8(8'h03);
        bus8.S   = 8'h55;
        bus8.Run = 1'b1;
        tick();
        tick();
        bus8.ClearA_LoadB = 1'b1;
        tick();
        bus8.ClearA_LoadB = 1'b0;
        repeat (6) tick();
        chk("midclr_done", {31'd0, bus8.Done}, 32'd1);
        prod8("midclr", 8'h00, 8'hFF, 1'b0);
        release8("midclr");

        // ClearA_LoadB and Run together: load first, start on next edge.
        bus8.S            = 8'h02;
        bus8.ClearA_LoadB = 1'b1;
        bus8.Run          = 1'b1;
        tick();
        bus8.ClearA_LoadB = 1'b0;
        chk("both_busy0", {31'd0, bus8.Busy}, 32'd0);
        chk("both_B", {24'd0, bus8.Bval}, 32'h02);
        tick();
        chk("both_busy1", {31'd0, bus8.Busy}, 32'd1);
        repeat (8) tick();
        chk("both_done", {31'd0, bus8.Done}, 32'd1);
        prod8("both", 8'h00, 8'h04, 1'b0);
        release8("both");

        // Reset in the 3rd compute cycle clears everything without a clock edge.
        load8(8'h0F);
        bus8.S   = 8'h03;
        bus8.Run = 1'b1;
        tick();
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        prod8("midrst", 8'h00, 8'h00, 1'b0);
        chk("midrst_busy", {31'd0, bus8.Busy}, 32'd0);
        chk("midrst_done", {31'd0, bus8.Done}, 32'd0);
        bus8.Run = 1'b0;
        #1;
        rst = 1'b0;
        tick();
        load8(8'h05);
        run8("after_rst", 8'h06);
        prod8("after_rst", 8'h00, 8'h1E, 1'b0);
        release8("after_rst");

`ifdef SEQ_MULT_UNSIGNED_EN
        // 255 * 255 = 0xFE01 unsigned; -1 * -1 = 1 signed.
        bus8.Unsigned = 1'b1;
        load8(8'hFF);
        run8("uns", 8'hFF);
        bus8.Unsigned = 1'b0;
        prod8("uns", 8'hFE, 8'h01, 1'b0);
        release8("uns");
        load8(8'hFF);
        run8("sgn", 8'hFF);
        prod8("sgn", 8'h00, 8'h01, 1'b0);
        release8("sgn");
`endif

        // WIDTH=16: 0x8000 * 0x8000 = 0x4000_0000, 17-cycle latency.
        bus16.S            = 16'h8000;
        bus16.ClearA_LoadB = 1'b1;
        tick();
        bus16.ClearA_LoadB = 1'b0;
        bus16.Run          = 1'b1;
        tick();
        chk("w16_busy", {31'd0, bus16.Busy}, 32'd1);
        repeat (15) tick();
        chk("w16_done_early", {31'd0, bus16.Done}, 32'd0);
        tick();
        chk("w16_done", {31'd0, bus16.Done}, 32'd1);
        chk("w16_A", {16'd0, bus16.Aval}, 32'h4000);
        chk("w16_B", {16'd0, bus16.Bval}, 32'h0000);
        chk("w16_X", {31'd0, bus16.X}, 32'd0);
        bus16.Run = 1'b0;
        tick();
        chk("w16_rel_done", {31'd0, bus16.Done}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_seq_multiplier_n
